gpu_rect_raster: RTL and testbench
==================================

Name: gpu_rect_raster

Overview:
- Parametrised rectangle rasteriser; successor to the single-mode fill-rect walker.
- Takes two corners in any order, normalises and clips them to the screen, then emits one pixel coordinate per cycle in row-major order with colour.
- Modes: solid fill and 1-pixel outline.
- Output uses a valid/ready handshake so the framebuffer writer can apply backpressure. Sits between the command decoder and the framebuffer write arbiter.

Parameters:
- WIDTH_BITS, 10, x coordinate width
- HEIGHT_BITS, 9, y coordinate width
- SCREEN_W, 640, visible width; legal x is 0..SCREEN_W-1
- SCREEN_H, 480, visible height; legal y is 0..SCREEN_H-1
- CHANNEL_BITS, 8, bits per colour channel

Ports:
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- start_i  in  1  command strobe; sampled only in IDLE
- mode_i  in  1  0 = fill, 1 = outline
- x1_i  in  WIDTH_BITS  corner A x
- y1_i  in  HEIGHT_BITS  corner A y
- x2_i  in  WIDTH_BITS  corner B x
- y2_i  in  HEIGHT_BITS  corner B y
- rgb_i  in  3*CHANNEL_BITS  colour {r,g,b}
- abort_i  in  1  cancel current command
- pix_valid_o  out  1  pixel output valid
- pix_ready_i  in  1  downstream accepts pixel
- x_o  out  WIDTH_BITS  pixel x
- y_o  out  HEIGHT_BITS  pixel y
- rgb_o  out  3*CHANNEL_BITS  pixel colour
- busy_o  out  1  command in progress
- done_o  out  1  one-cycle completion pulse

Behaviour:
- Interface: one clock (clk). Reset is asynchronous and active-low (n_rst).
- Reset values: all outputs 0; state IDLE.
- States: IDLE, SETUP, RUN, DONE.
- IDLE:
  - When start_i=1, register the corners, mode and colour, then go to SETUP. A level-high start_i is accepted once per IDLE visit; no edge detector.
  - busy_o=0 in IDLE only.
- SETUP (1 cycle):
  - xmin=min(x1,x2), xmax=max(x1,x2); likewise ymin/ymax.
  - If xmin>=SCREEN_W or ymin>=SCREEN_H, the rectangle is empty: go to DONE with no pixels.
  - Otherwise clamp xmax to SCREEN_W-1 and ymax to SCREEN_H-1. Record whether each edge was clipped.
  - Load cursor (x,y)=(xmin,ymin) and go to RUN.
- RUN:
  - pix_valid_o=1; x_o/y_o equal the cursor; rgb_o is the latched colour.
  - Cursor advances only on the cycle where pix_valid_o && pix_ready_i. Outputs are held stable while ready=0.
  - Fill advance: x==xmax ? (x=xmin, y=y+1) : x=x+1.
  - Outline advance: on row ymin or ymax, identical to fill. On interior rows, jump from x=xmin to x=xmax (skip interior), except when xmin==xmax.
  - A clipped right or bottom edge is still drawn at the clamp boundary. Outline drawing is literal on the clipped box.
  - Accepting the pixel (xmax,ymax) moves the state to DONE.
  - Each pixel is emitted exactly once, including degenerate cases: width 1, height 1, and a single point.
- DONE (1 cycle): done_o=1, busy_o=1, pix_valid_o=0, then IDLE.
- abort_i: in SETUP or RUN, takes priority over handshake advance. Next state is DONE, pix_valid_o drops next cycle, done_o pulses normally. Ignored in IDLE and DONE.
- Arithmetic: comparisons are unsigned; cursor increments never exceed xmax/ymax, so no wrap.
- Reset mid-operation: immediate return to IDLE, outputs 0, no done_o.
- Throughput: 1 pixel/cycle with ready tied high. Latency from start accepted to first valid is 2 cycles.

Decomposition:
- Shared package gpu_pkg: WIDTH_BITS, HEIGHT_BITS, SCREEN_W, SCREEN_H, CHANNEL_BITS, the state enum raster_state_t, mode constants MODE_FILL/MODE_OUTLINE, and an rgb_t struct.
- Sub-module gpu_rect_setup: combinational normalise and clip. It is reused later by the blit engine.

Test Plan:
- Fill with mode 0, (2,3)-(4,4), ready=1 -> 6 pixels in order (2,3),(3,3),(4,3),(2,4),(3,4),(4,4), one per cycle; done_o the cycle after the last; first valid 2 cycles after start.
- Swapped corners (4,4)-(2,3) -> identical sequence to the previous test.
- Outline (0,0)-(3,2) -> 10 pixels: row 0 x=0..3, row 1 (0,1),(3,1), row 2 x=0..3. Also (5,5)-(5,7) -> 3 pixels.
- Clipping (630,470)-(700,500) -> x 630..639, y 470..479, 100 pixels, last (639,479). Also (650,10)-(660,20) -> no valid, done_o 2 cycles after start.
- Backpressure: ready=0 for 3 cycles on pixel (3,3) -> x_o/y_o/rgb_o stable, no skip or duplicate. Hold start_i high -> second command starts only after IDLE.
- abort_i in RUN at (3,3) -> valid low next cycle, done_o pulses. Separately, n_rst low mid-RUN -> all outputs 0 and no done_o.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared definitions for the rectangle rasteriser and its setup stage.
//   Coordinate widths, screen size, colour width, FSM state type,
//   draw-mode constants, colour and rectangle structs.
package gpu_pkg;

  localparam int WIDTH_BITS   = 10;
  localparam int HEIGHT_BITS  = 9;
  localparam int SCREEN_W     = 640;
  localparam int SCREEN_H     = 480;
  localparam int CHANNEL_BITS = 8;

  typedef logic [WIDTH_BITS-1:0]  xcoord_t;
  typedef logic [HEIGHT_BITS-1:0] ycoord_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_RUN,
    ST_DONE
  } raster_state_t;

  localparam logic MODE_FILL    = 1'b0;
  localparam logic MODE_OUTLINE = 1'b1;

  typedef struct packed {
    logic [CHANNEL_BITS-1:0] r;
    logic [CHANNEL_BITS-1:0] g;
    logic [CHANNEL_BITS-1:0] b;
  } rgb_t;

  // Normalised box. xmax/ymax are the raw far corner; clip_r/clip_b say the
  // far corner lies off-screen and the screen edge must be used instead.
  typedef struct packed {
    xcoord_t xmin;
    xcoord_t xmax;
    ycoord_t ymin;
    ycoord_t ymax;
    logic    clip_r;
    logic    clip_b;
    logic    empty;
  } rect_t;

endpackage

// File: rtl/gpu_rect_raster_if.sv
// Command + pixel-stream bundle for gpu_rect_raster.
//   Command side: start_i, mode_i, x1_i/y1_i, x2_i/y2_i, rgb_i, abort_i.
//   Pixel side:   pix_valid_o/pix_ready_i handshake carrying x_o, y_o, rgb_o.
//   Status:       busy_o, done_o.
// Suffixes are from the rasteriser's point of view; slave = rasteriser,
// master = command source / pixel consumer.
interface gpu_rect_raster_if;
  import gpu_pkg::*;

  logic    start_i;
  logic    mode_i;
  xcoord_t x1_i;
  ycoord_t y1_i;
  xcoord_t x2_i;
  ycoord_t y2_i;
  rgb_t    rgb_i;
  logic    abort_i;
  logic    pix_valid_o;
  logic    pix_ready_i;
  xcoord_t x_o;
  ycoord_t y_o;
  rgb_t    rgb_o;
  logic    busy_o;
  logic    done_o;

  modport slave (
    input  start_i, mode_i, x1_i, y1_i, x2_i, y2_i, rgb_i, abort_i, pix_ready_i,
    output pix_valid_o, x_o, y_o, rgb_o, busy_o, done_o
  );

  modport master (
    output start_i, mode_i, x1_i, y1_i, x2_i, y2_i, rgb_i, abort_i, pix_ready_i,
    input  pix_valid_o, x_o, y_o, rgb_o, busy_o, done_o
  );

endinterface

// File: rtl/gpu_rect_setup.sv
// Combinational normalise/clip classifier for a two-corner rectangle.
//   x1_i/y1_i, x2_i/y2_i : corners in any order
//   box_o                : min/max corners, right/bottom clip flags, empty flag
// Unsigned compares throughout. Empty means the near corner is already
// off-screen, so nothing of the box is visible.
module gpu_rect_setup
  import gpu_pkg::*;
(
  input  xcoord_t x1_i,
  input  ycoord_t y1_i,
  input  xcoord_t x2_i,
  input  ycoord_t y2_i,
  output rect_t   box_o
);

  localparam xcoord_t XLAST = xcoord_t'(SCREEN_W - 1);
  localparam ycoord_t YLAST = ycoord_t'(SCREEN_H - 1);

  always_comb begin
    box_o        = '0;
    box_o.xmin   = (x1_i < x2_i) ? x1_i : x2_i;
    box_o.xmax   = (x1_i < x2_i) ? x2_i : x1_i;
    box_o.ymin   = (y1_i < y2_i) ? y1_i : y2_i;
    box_o.ymax   = (y1_i < y2_i) ? y2_i : y1_i;
    box_o.clip_r = box_o.xmax > XLAST;
    box_o.clip_b = box_o.ymax > YLAST;
    box_o.empty  = (box_o.xmin > XLAST) || (box_o.ymin > YLAST);
  end

endmodule

// File: rtl/gpu_rect_raster.sv
// Rectangle rasteriser: walks a clipped box in row-major order, one pixel
// per accepted handshake, in fill or 1-pixel outline mode.
//   clk, n_rst : clock, async active-low reset
//   bus        : command inputs, pixel valid/ready stream, busy/done status
// IDLE latches a command, SETUP normalises/clips (1 cycle), RUN emits
// pixels, DONE pulses done_o for one cycle. abort_i in SETUP/RUN jumps to
// DONE. All outputs are registers.
module gpu_rect_raster
  import gpu_pkg::*;
(
  input  logic              clk,
  input  logic              n_rst,
  gpu_rect_raster_if.slave  bus
);

  localparam xcoord_t XLAST = xcoord_t'(SCREEN_W - 1);
  localparam ycoord_t YLAST = ycoord_t'(SCREEN_H - 1);

  raster_state_t state_q;
  logic          mode_q;
  xcoord_t       x1_q, x2_q;
  ycoord_t       y1_q, y2_q;
  rgb_t          col_q;
  xcoord_t       xmin_q, xmax_q, cx_q, cx_d;
  ycoord_t       ymin_q, ymax_q, cy_q, cy_d;
  logic          valid_q, busy_q, done_q;

  rect_t         box;
  logic          last_px;
  logic          interior;

  gpu_rect_setup u_setup (
    .x1_i  (x1_q),
    .y1_i  (y1_q),
    .x2_i  (x2_q),
    .y2_i  (y2_q),
    .box_o (box)
  );

  // Cursor advance. End of row always wraps; in outline mode an interior
  // row jumps straight from the left edge to the right edge. When
  // xmin==xmax the cursor already sits on xmax, so the wrap branch wins.
  always_comb begin
    last_px  = (cx_q == xmax_q) && (cy_q == ymax_q);
    interior = (cy_q != ymin_q) && (cy_q != ymax_q);
    cx_d     = cx_q + xcoord_t'(1);
    cy_d     = cy_q;
    if (cx_q == xmax_q) begin
      cx_d = xmin_q;
      cy_d = cy_q + ycoord_t'(1);
    end else if (mode_q == MODE_OUTLINE && interior) begin
      cx_d = xmax_q;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_FILL;
      x1_q    <= '0;
      x2_q    <= '0;
      y1_q    <= '0;
      y2_q    <= '0;
      col_q   <= '0;
      xmin_q  <= '0;
      xmax_q  <= '0;
      ymin_q  <= '0;
      ymax_q  <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start_i) begin
            mode_q  <= bus.mode_i;
            x1_q    <= bus.x1_i;
            x2_q    <= bus.x2_i;
            y1_q    <= bus.y1_i;
            y2_q    <= bus.y2_i;
            col_q   <= bus.rgb_i;
            busy_q  <= 1'b1;
            state_q <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (bus.abort_i || box.empty) begin
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            xmin_q  <= box.xmin;
            xmax_q  <= box.clip_r ? XLAST : box.xmax;
            ymin_q  <= box.ymin;
            ymax_q  <= box.clip_b ? YLAST : box.ymax;
            cx_q    <= box.xmin;
            cy_q    <= box.ymin;
            valid_q <= 1'b1;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (bus.abort_i || (bus.pix_ready_i && last_px)) begin
            valid_q <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else if (bus.pix_ready_i) begin
            cx_q <= cx_d;
            cy_q <= cy_d;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.pix_valid_o = valid_q;
  assign bus.x_o         = cx_q;
  assign bus.y_o         = cy_q;
  assign bus.rgb_o       = col_q;
  assign bus.busy_o      = busy_q;
  assign bus.done_o      = done_q;

endmodule

// File: tb/tb_gpu_rect_raster.sv
// Bench for gpu_rect_raster: directed and randomized commands checked
// against a pixel-list model built from the drawing rules.
module tb_gpu_rect_raster;
  import gpu_pkg::*;

  logic clk;
  logic n_rst;
  int   total;
  int   bad;
  int   exp_x[$];
  int   exp_y[$];

  gpu_rect_raster_if bus ();

  gpu_rect_raster dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected pixel list: every pixel of the visible box in row-major order,
  // restricted to the border in outline mode.
  task automatic build_exp(input int x1, input int y1, input int x2, input int y2, input bit mode);
    int xa, xb, ya, yb;
    exp_x.delete();
    exp_y.delete();
    xa = (x1 < x2) ? x1 : x2;
    xb = (x1 < x2) ? x2 : x1;
    ya = (y1 < y2) ? y1 : y2;
    yb = (y1 < y2) ? y2 : y1;
    if (xa >= SCREEN_W || ya >= SCREEN_H) return;
    if (xb > SCREEN_W - 1) xb = SCREEN_W - 1;
    if (yb > SCREEN_H - 1) yb = SCREEN_H - 1;
    for (int y = ya; y <= yb; y++)
      for (int x = xa; x <= xb; x++)
        if (!mode || y == ya || y == yb || x == xa || x == xb) begin
          exp_x.push_back(x);
          exp_y.push_back(y);
        end
  endtask

  // Issue one command and follow it to completion.
  //   rnd_ready : random backpressure instead of ready tied high
  //   hold      : leave start_i high afterwards
  //   stall_*   : hold ready low for 3 cycles when this pixel is shown
  //   abort_*   : raise abort_i when this pixel is shown
  task automatic run_cmd(input int x1, input int y1, input int x2, input int y2,
                         input bit mode, input bit rnd_ready, input bit hold,
                         input int stall_x, input int stall_y,
                         input int abort_x, input int abort_y);
    int          n, cyc, stall_left, px, py;
    bit          seen_done, first_seen, aborted, abort_pend, r;
    logic [23:0] col;
    col = 24'($urandom);
    build_exp(x1, y1, x2, y2, mode);
    n = exp_x.size();
    bus.x1_i = WIDTH_BITS'(x1);
    bus.y1_i = HEIGHT_BITS'(y1);
    bus.x2_i = WIDTH_BITS'(x2);
    bus.y2_i = HEIGHT_BITS'(y2);
    bus.mode_i = mode;
    bus.rgb_i = col;
    bus.abort_i = 1'b0;
    bus.pix_ready_i = 1'b1;
    bus.start_i = 1'b1;
    cyc = 0; stall_left = 3;
    seen_done = 0; first_seen = 0; aborted = 0; abort_pend = 0;
    while (!seen_done && cyc < 8 * n + 40) begin
      step();
      cyc++;
      bus.start_i = hold;
      bus.abort_i = 1'b0;
      if (cyc == 1) begin
        chk("setup_busy", 32'(bus.busy_o), 1);
        chk("setup_novalid", 32'(bus.pix_valid_o), 0);
      end
      if (abort_pend) begin
        chk("abort_valid_drop", 32'(bus.pix_valid_o), 0);
        chk("abort_done", 32'(bus.done_o), 1);
        abort_pend = 0;
      end
      if (bus.done_o) begin
        seen_done = 1;
        chk("done_novalid", 32'(bus.pix_valid_o), 0);
        chk("done_busy", 32'(bus.busy_o), 1);
        if (!aborted) chk("done_all_pixels", 32'(exp_x.size()), 0);
        if (!rnd_ready && stall_x < 0 && !aborted) chk("done_cycle", 32'(cyc), 32'(n + 2));
      end else if (bus.pix_valid_o) begin
        if (exp_x.size() == 0) begin
          chk("extra_pixel", 32'(bus.pix_valid_o), 0);
        end else begin
          px = exp_x[0];
          py = exp_y[0];
          chk("pix_x", 32'(bus.x_o), 32'(px));
          chk("pix_y", 32'(bus.y_o), 32'(py));
          chk("pix_rgb", 32'(bus.rgb_o), 32'(col));
          if (!first_seen) begin
            first_seen = 1;
            chk("first_latency", 32'(cyc), 2);
          end
          r = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
          if (px == stall_x && py == stall_y && stall_left > 0) begin
            r = 1'b0;
            stall_left--;
          end
          if (px == abort_x && py == abort_y && !aborted) begin
            bus.abort_i = 1'b1;
            aborted = 1;
            abort_pend = 1;
            r = 1'b1;
          end
          bus.pix_ready_i = r;
          if (r && !abort_pend) begin
            void'(exp_x.pop_front());
            void'(exp_y.pop_front());
          end
        end
      end
    end
    if (!seen_done) chk("timeout_done", 32'(seen_done), 1);
    bus.pix_ready_i = 1'b1;
    step();
    chk("idle_busy", 32'(bus.busy_o), 0);
    chk("idle_done", 32'(bus.done_o), 0);
    chk("idle_valid", 32'(bus.pix_valid_o), 0);
  endtask

  initial begin
    int rx1, ry1, rx2, ry2;
    total = 0;
    bad = 0;
    n_rst = 1'b0;
    bus.start_i = 1'b0;
    bus.mode_i = 1'b0;
    bus.x1_i = '0;
    bus.y1_i = '0;
    bus.x2_i = '0;
    bus.y2_i = '0;
    bus.rgb_i = '0;
    bus.abort_i = 1'b0;
    bus.pix_ready_i = 1'b1;
    step();
    step();
    chk("rst_valid", 32'(bus.pix_valid_o), 0);
    chk("rst_busy", 32'(bus.busy_o), 0);
    chk("rst_done", 32'(bus.done_o), 0);
    chk("rst_xy", 32'({bus.x_o, bus.y_o}), 0);
    chk("rst_rgb", 32'(bus.rgb_o), 0);
    n_rst = 1'b1;
    step();

    // basic fill, swapped corners, outline, degenerate shapes
    run_cmd(2, 3, 4, 4, MODE_FILL, 0, 0, -1, -1, -1, -1);
    run_cmd(4, 4, 2, 3, MODE_FILL, 0, 0, -1, -1, -1, -1);
    run_cmd(0, 0, 3, 2, MODE_OUTLINE, 0, 0, -1, -1, -1, -1);
    run_cmd(5, 5, 5, 7, MODE_OUTLINE, 0, 0, -1, -1, -1, -1);
    run_cmd(7, 7, 7, 7, MODE_FILL, 0, 0, -1, -1, -1, -1);
    run_cmd(3, 9, 12, 9, MODE_OUTLINE, 0, 0, -1, -1, -1, -1);
    run_cmd(10, 10, 16, 15, MODE_OUTLINE, 0, 0, -1, -1, -1, -1);

    // clipping: partly off-screen, fully off-screen, exactly at the edge
    run_cmd(630, 470, 700, 500, MODE_FILL, 0, 0, -1, -1, -1, -1);
    run_cmd(700, 500, 630, 470, MODE_OUTLINE, 0, 0, -1, -1, -1, -1);
    run_cmd(650, 10, 660, 20, MODE_FILL, 0, 0, -1, -1, -1, -1);
    run_cmd(10, 480, 20, 490, MODE_FILL, 0, 0, -1, -1, -1, -1);
    run_cmd(636, 476, 639, 479, MODE_FILL, 0, 0, -1, -1, -1, -1);

    // backpressure stall on (3,3)
    run_cmd(2, 3, 5, 5, MODE_FILL, 0, 0, 3, 3, -1, -1);

    // start_i held high: second command starts only from IDLE
    run_cmd(2, 3, 4, 4, MODE_FILL, 0, 1, -1, -1, -1, -1);
    run_cmd(1, 1, 4, 4, MODE_OUTLINE, 0, 0, -1, -1, -1, -1);

    // abort in RUN
    run_cmd(2, 3, 6, 6, MODE_FILL, 0, 0, -1, -1, 3, 3);

    // reset mid-RUN
    bus.x1_i = 10'd2; bus.y1_i = 9'd3; bus.x2_i = 10'd9; bus.y2_i = 9'd8;
    bus.mode_i = MODE_FILL; bus.rgb_i = 24'h123456; bus.pix_ready_i = 1'b1;
    bus.start_i = 1'b1;
    step();
    bus.start_i = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("pre_rst_valid", 32'(bus.pix_valid_o), 1);
    n_rst = 1'b0;
    #1;
    chk("midrst_valid", 32'(bus.pix_valid_o), 0);
    chk("midrst_busy", 32'(bus.busy_o), 0);
    chk("midrst_xy", 32'({bus.x_o, bus.y_o}), 0);
    chk("midrst_rgb", 32'(bus.rgb_o), 0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("midrst_nodone", 32'(bus.done_o), 0);
    end
    n_rst = 1'b1;
    step();
    chk("postrst_nodone", 32'(bus.done_o), 0);
    run_cmd(3, 3, 5, 4, MODE_FILL, 0, 0, -1, -1, -1, -1);

    // randomized small boxes near the origin and near the clip corner
    for (int k = 0; k < 14; k++) begin
      rx1 = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 40)) : int'($urandom_range(620, 660));
      ry1 = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 40)) : int'($urandom_range(460, 500));
      rx2 = rx1 + int'($urandom_range(0, 16)) - 8;
      ry2 = ry1 + int'($urandom_range(0, 16)) - 8;
      if (rx2 < 0) rx2 = 0;
      if (ry2 < 0) ry2 = 0;
      run_cmd(rx1, ry1, rx2, ry2, 1'($urandom_range(0, 1)), 1, 0, -1, -1, -1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
